// File: rtl/io_reg_responder.sv
// Memory-mapped register responder: a 64-byte window holding 15 R/W registers
// and a free-running cycle counter, answered after a fixed, programmable latency.
module io_reg_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iIO_REQ,
  output logic        oIO_BUSY,
  input  logic [1:0]  iIO_ORDER,
  input  logic        iIO_RW,
  input  logic [31:0] iIO_ADDR,
  input  logic [31:0] iIO_DATA,
  output logic        oIO_VALID,
  output logic [31:0] oIO_DATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic        busy_q;
  logic        valid_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic [31:0] cycle_cnt_q;
  logic [31:0] regs_q [15];
  logic [31:0] regs_d [15];

  logic        hit;
  logic        accept;
  logic [3:0]  offset;
  logic [4:0]  lane_shift;
  logic [31:0] lane_mask;
  logic [31:0] sel_word;
  logic [31:0] rd_data;
  logic [31:0] wr_word;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit        = (iIO_ADDR[31:6] == BASE_ADDR[31:6]);
    offset     = iIO_ADDR[5:2];
    accept     = (state_q == ST_IDLE) && iIO_REQ && hit;
    lane_shift = '0;
    lane_mask  = '0;

    // Offset 0xF falls through to the counter; it never matches a register.
    sel_word = cycle_cnt_q;
    for (int i = 0; i < 15; i++) begin
      if (offset == 4'(i)) sel_word = regs_q[i];
    end

    case (iIO_ORDER)
      2'b00: begin
        lane_shift = {iIO_ADDR[1:0], 3'b000};
        lane_mask  = 32'h0000_00FF << lane_shift;
      end
      2'b01: begin
        lane_shift = {iIO_ADDR[1], 4'b0000};
        lane_mask  = 32'h0000_FFFF << lane_shift;
      end
      2'b10:   lane_mask = '1;
      default: lane_mask = '0;
    endcase

    rd_data = (sel_word & lane_mask) >> lane_shift;
    wr_word = iIO_DATA << lane_shift;

    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (accept && !iIO_RW && (offset == 4'(i)))
        regs_d[i] = (regs_q[i] & ~lane_mask) | (wr_word & lane_mask);
    end
  end

  // NOTE: the register bank is plain flops, not a RAM macro, so it can and must
  // be cleared by reset along with the rest of the state.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      rdata_q     <= '0;
      cycle_cnt_q <= '0;
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop reading pre-edge values.
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
      valid_q <= 1'b0;
      data_q  <= '0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            busy_q  <= 1'b1;
            rdata_q <= iIO_RW ? rd_data : '0;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              valid_q <= 1'b1;
              data_q  <= iIO_RW ? rd_data : '0;
            end else begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd0) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            data_q  <= rdata_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oIO_BUSY  = busy_q;
  assign oIO_VALID = valid_q;
  assign oIO_DATA  = data_q;

endmodule

// File: tb/tb_io_reg_responder.sv
// Bench for io_reg_responder: three instances (different latency/base) checked
// every cycle against a transaction-level model, plus directed literal scenarios.
module tb_io_reg_responder;

  localparam int NK = 3;
  localparam int          W_P    [NK] = '{1, 0, 3};
  localparam logic [31:0] BASE_P [NK] = '{32'h0000_0000, 32'h0000_0040, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  order = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  busy_o;
  logic [2:0]  valid_o;
  logic [31:0] data_o0, data_o1, data_o2;

  always #5 clk = ~clk;

  io_reg_responder #(.BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1)) u_dut_a (
    .iCLOCK(clk), .iRESET(rst), .iIO_REQ(req), .oIO_BUSY(busy_o[0]), .iIO_ORDER(order),
    .iIO_RW(rw), .iIO_ADDR(addr), .iIO_DATA(wdata), .oIO_VALID(valid_o[0]), .oIO_DATA(data_o0));
  io_reg_responder #(.BASE_ADDR(32'h0000_0040), .WAIT_CYCLES(0)) u_dut_b (
    .iCLOCK(clk), .iRESET(rst), .iIO_REQ(req), .oIO_BUSY(busy_o[1]), .iIO_ORDER(order),
    .iIO_RW(rw), .iIO_ADDR(addr), .iIO_DATA(wdata), .oIO_VALID(valid_o[1]), .oIO_DATA(data_o1));
  io_reg_responder #(.BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3)) u_dut_c (
    .iCLOCK(clk), .iRESET(rst), .iIO_REQ(req), .oIO_BUSY(busy_o[2]), .iIO_ORDER(order),
    .iIO_RW(rw), .iIO_ADDR(addr), .iIO_DATA(wdata), .oIO_VALID(valid_o[2]), .oIO_DATA(data_o2));

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  // Transaction-level model: each instance remembers only its last accepted
  // request (cycle and response); busy/valid follow from cycle arithmetic.
  bit          pend   [NK];
  int          acc_t  [NK];
  logic [31:0] resp_d [NK];
  logic [31:0] mregs  [NK][15];
  logic [31:0] mcnt = '0;

  // Inputs for the next cycle, applied by step() after the compare.
  logic        n_rst = 1'b1, n_req = 1'b0, n_rw = 1'b0;
  logic [1:0]  n_order = 2'b00;
  logic [31:0] n_addr = '0, n_data = '0;

  logic        snap_busy  [NK];
  logic        snap_valid [NK];
  logic [31:0] snap_data  [NK];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle_no, got, exp);
    end
  endtask

  function automatic bit m_busy(int k);
    return pend[k] && (cycle_no > acc_t[k]) && (cycle_no <= acc_t[k] + 1 + W_P[k]);
  endfunction

  function automatic bit m_valid(int k);
    return pend[k] && (cycle_no == acc_t[k] + 1 + W_P[k]);
  endfunction

  function automatic logic [31:0] dut_data(int k);
    case (k)
      0:       return data_o0;
      1:       return data_o1;
      default: return data_o2;
    endcase
  endfunction

  task automatic model_advance();
    for (int k = 0; k < NK; k++) begin
      logic [31:0] base, word, mask;
      int          sh, off;
      base = BASE_P[k];
      if (rst) begin
        pend[k] = 0;
        for (int i = 0; i < 15; i++) mregs[k][i] = '0;
      end else if (!m_busy(k) && req && (addr[31:6] == base[31:6])) begin
        off  = int'(addr[5:2]);
        word = (off == 15) ? mcnt : mregs[k][off];
        sh   = 0;
        case (order)
          2'b00:   begin sh = 8 * int'(addr[1:0]); mask = 32'hFF << sh; end
          2'b01:   begin sh = 16 * int'(addr[1]);  mask = 32'hFFFF << sh; end
          2'b10:   mask = 32'hFFFF_FFFF;
          default: mask = 32'h0;
        endcase
        pend[k]   = 1;
        acc_t[k]  = cycle_no;
        resp_d[k] = rw ? ((word & mask) >> sh) : 32'h0;
        if (!rw && off != 15)
          mregs[k][off] = (mregs[k][off] & ~mask) | ((wdata << sh) & mask);
      end
    end
    mcnt = rst ? 32'h0 : mcnt + 32'd1;
    cycle_no++;
  endtask

  // One clock cycle: compare outputs of this cycle, then drive its inputs.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      logic e_valid;
      e_valid = m_valid(k);
      check($sformatf("busy%0d", k),  {31'b0, busy_o[k]},  {31'b0, m_busy(k)});
      check($sformatf("valid%0d", k), {31'b0, valid_o[k]}, {31'b0, e_valid});
      check($sformatf("data%0d", k),  dut_data(k), e_valid ? resp_d[k] : 32'h0);
      snap_busy[k]  = busy_o[k];
      snap_valid[k] = valid_o[k];
      snap_data[k]  = dut_data(k);
    end
    rst   = n_rst;
    req   = n_req;
    order = n_order;
    rw    = n_rw;
    addr  = n_addr;
    wdata = n_data;
    model_advance();
  endtask

  task automatic drive(input logic r, input logic q, input logic [1:0] o, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    n_rst = r; n_req = q; n_order = o; n_rw = w; n_addr = a; n_data = d;
    step();
  endtask

  // One request followed by idle cycles; reports latency, data and busy pattern of instance k.
  task automatic txn(input int k, input logic [1:0] o, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] got,
                     output logic [7:0] bpat);
    drive(1'b0, 1'b1, o, w, a, d);
    bpat = '0;
    bpat[0] = snap_busy[k];
    lat = -1;
    got = '0;
    for (int i = 1; i < 8; i++) begin
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      bpat[i] = snap_busy[k];
      if (snap_valid[k] && lat < 0) begin
        lat = i;
        got = snap_data[k];
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] got, c1, c2, c3;
    logic [7:0]  bpat, vpat;
    logic [10:0] rpat;
    logic [31:0] rdat;

    for (int k = 0; k < NK; k++) begin
      pend[k] = 0; acc_t[k] = 0; resp_d[k] = '0;
      for (int i = 0; i < 15; i++) mregs[k][i] = '0;
    end

    repeat (3) drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("reset_busy",  {31'b0, snap_busy[0]},  32'h0);
    check("reset_valid", {31'b0, snap_valid[0]}, 32'h0);
    check("reset_data",  snap_data[0], 32'h0);
    repeat (2) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    // Word write then read-back.
    txn(0, 2'b10, 1'b0, 32'h04, 32'hDEAD_BEEF, lat, got, bpat);
    check("wr_word_lat", lat, 2);
    check("wr_word_data", got, 32'h0);
    txn(0, 2'b10, 1'b1, 32'h04, 32'h0, lat, got, bpat);
    check("rd_word_lat", lat, 2);
    check("rd_word_data", got, 32'hDEAD_BEEF);
    check("rd_word_busy", {24'b0, bpat}, 32'h0000_0006);

    // Byte and halfword lanes.
    txn(0, 2'b10, 1'b0, 32'h08, 32'h0, lat, got, bpat);
    txn(0, 2'b00, 1'b0, 32'h0A, 32'h0000_00AA, lat, got, bpat);
    txn(0, 2'b01, 1'b0, 32'h08, 32'h0000_1234, lat, got, bpat);
    txn(0, 2'b10, 1'b1, 32'h08, 32'h0, lat, got, bpat);
    check("lane_word", got, 32'h00AA_1234);
    txn(0, 2'b00, 1'b1, 32'h0B, 32'h0, lat, got, bpat);
    check("lane_byte3", got, 32'h0);
    txn(0, 2'b01, 1'b1, 32'h0A, 32'h0, lat, got, bpat);
    check("lane_half1", got, 32'h0000_00AA);
    txn(0, 2'b11, 1'b1, 32'h08, 32'h0, lat, got, bpat);
    check("order11_lat", lat, 2);
    check("order11_data", got, 32'h0);

    // Request held high while busy: second address waits for the IDLE cycle.
    vpat = '0; bpat = '0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)     drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1111_1111);
      else if (i < 4) drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h2222_2222);
      else            drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      vpat[i] = snap_valid[0];
      bpat[i] = snap_busy[0];
    end
    check("hold_valid_pat", {24'b0, vpat}, 32'h0000_0024);
    check("hold_busy_pat",  {24'b0, bpat}, 32'h0000_0036);
    txn(0, 2'b10, 1'b1, 32'h14, 32'h0, lat, got, bpat);
    check("hold_second", got, 32'h2222_2222);
    txn(0, 2'b10, 1'b1, 32'h10, 32'h0, lat, got, bpat);
    check("hold_first", got, 32'h1111_1111);

    // Out-of-window request on the base-0 instance.
    txn(0, 2'b10, 1'b0, 32'h40, 32'h1, lat, got, bpat);
    check("miss_lat", lat, -1);
    check("miss_busy", {24'b0, bpat}, 32'h0);

    // Counter: reads 10 cycles apart, write ignored.
    txn(0, 2'b10, 1'b1, 32'h3C, 32'h0, lat, c1, bpat);
    repeat (2) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    txn(0, 2'b10, 1'b1, 32'h3C, 32'h0, lat, c2, bpat);
    check("cnt_delta10", c2 - c1, 32'd10);
    txn(0, 2'b10, 1'b0, 32'h3C, 32'h5, lat, got, bpat);
    check("cnt_wr_ack", lat, 2);
    txn(0, 2'b10, 1'b1, 32'h3C, 32'h0, lat, c3, bpat);
    check("cnt_unaffected", c3 - c1, 32'd26);

    // Latency on the other instances.
    txn(1, 2'b10, 1'b0, 32'h48, 32'h0000_5A5A, lat, got, bpat);
    check("w0_wr_lat", lat, 1);
    txn(1, 2'b10, 1'b1, 32'h48, 32'h0, lat, got, bpat);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_data", got, 32'h0000_5A5A);
    check("w0_busy", {24'b0, bpat}, 32'h0000_0002);
    txn(2, 2'b10, 1'b1, 32'h04, 32'h0, lat, got, bpat);
    check("w3_rd_lat", lat, 4);
    check("w3_rd_data", got, 32'hDEAD_BEEF);

    // Reset during WAIT, then accept in the first cycle after release.
    rpat = '0; rdat = '0;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h04, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("rst_in_wait_busy", {31'b0, snap_busy[0]}, 32'h1);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    check("rst_busy",  {31'b0, snap_busy[0]},  32'h0);
    check("rst_valid", {31'b0, snap_valid[0]}, 32'h0);
    check("rst_data",  snap_data[0], 32'h0);
    rpat[2] = snap_valid[0];
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rpat[3] = snap_valid[0];
    drive(1'b0, 1'b1, 2'b10, 1'b1, 32'h04, 32'h0);
    rpat[4] = snap_valid[0];
    for (int i = 5; i < 11; i++) begin
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      rpat[i] = snap_valid[0];
      if (i == 6) rdat = snap_data[0];
    end
    check("rst_valid_pat", {21'b0, rpat}, 32'h0000_0040);
    check("rst_reg_cleared", rdat, 32'h0);

    // Randomised traffic across both windows, misses, and occasional resets.
    for (int n = 0; n < 2500; n++) begin
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = {26'h0, 6'($urandom)};
      else if (sel < 9) a = {26'h1, 6'($urandom)};
      else              a = $urandom;
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
            2'($urandom), 1'($urandom), a, $urandom);
    end
    repeat (6) drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
